fft_frame_scheduler: RTL and testbench



---
 rtl/fft_frame_scheduler.sv | 162 ++++++++++++++++
 tb/tb_fft_frame_scheduler.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_scheduler.sv
// ============================================================================
//  Module   : fft_frame_scheduler
//  Purpose  : Frame sequencer for the FFT pitch-detect path: frame release,
//             bin counting, peak gating with silence hold-over, watchdog.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module fft_frame_scheduler #(
    parameter int NSamples       = 1024,
    parameter int W_K            = 16,
    parameter int W_MAG          = 33,
    parameter int TIMEOUT_CYCLES = 8192,
    parameter int HOLD_FRAMES    = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             frame_ready,
    output logic             frame_start,
    input  logic             bin_valid,
    input  logic             peak_valid,
    input  logic [W_K-1:0]   peak_k,
    input  logic [W_MAG-1:0] peak_mag,
    input  logic [W_MAG-1:0] threshold,
    output logic             pitch_valid,
    input  logic             pitch_ready,
    output logic [W_K-1:0]   pitch_data,
    output logic [15:0]      frame_count,
    output logic [7:0]       timeout_count,
    output logic [2:0]       state
);

    localparam int c_BIN_W = $clog2(NSamples + 1);
    localparam int c_WD_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int c_SIL_W = $clog2(HOLD_FRAMES + 2);

    typedef enum logic [2:0] {
        c_IDLE       = 3'd0,
        c_WAIT_FRAME = 3'd1,
        c_RUN        = 3'd2,
        c_WAIT_PEAK  = 3'd3,
        c_PUBLISH    = 3'd4
    } state_t;

    state_t               r_state_q,         w_state_d;
    logic                 r_frame_start_q,   w_frame_start_d;
    logic                 r_pitch_valid_q,   w_pitch_valid_d;
    logic [W_K-1:0]       r_pitch_data_q,    w_pitch_data_d;
    logic [15:0]          r_frame_count_q,   w_frame_count_d;
    logic [7:0]           r_timeout_count_q, w_timeout_count_d;
    logic [W_K-1:0]       r_last_pitch_q,    w_last_pitch_d;
    logic [c_SIL_W-1:0]   r_silent_cnt_q,    w_silent_cnt_d;
    logic [c_BIN_W-1:0]   r_bin_cnt_q,       w_bin_cnt_d;
    logic [c_WD_W-1:0]    r_watchdog_q,      w_watchdog_d;
    logic                 w_last_bin;
    logic                 w_peak_accept;

    always_comb begin
        w_state_d         = r_state_q;
        w_frame_start_d   = 1'b0;
        w_pitch_valid_d   = r_pitch_valid_q;
        w_pitch_data_d    = r_pitch_data_q;
        w_frame_count_d   = r_frame_count_q;
        w_timeout_count_d = r_timeout_count_q;
        w_last_pitch_d    = r_last_pitch_q;
        w_silent_cnt_d    = r_silent_cnt_q;
        w_bin_cnt_d       = r_bin_cnt_q;
        w_watchdog_d      = r_watchdog_q;
        w_last_bin        = bin_valid && (r_bin_cnt_q == c_BIN_W'(NSamples - 1));
        w_peak_accept     = 1'b0;

        case (r_state_q)
            c_IDLE: begin
                if (enable) w_state_d = c_WAIT_FRAME;
            end
            c_WAIT_FRAME: begin
                if (frame_ready) begin
                    w_frame_start_d = 1'b1;
                    w_state_d       = c_RUN;
                    w_bin_cnt_d     = '0;
                    w_watchdog_d    = c_WD_W'(TIMEOUT_CYCLES);
                end else if (!enable) begin
                    w_state_d = c_IDLE;
                end
            end
            c_RUN, c_WAIT_PEAK: begin
                w_watchdog_d = r_watchdog_q - 1'b1;
                // In RUN a peak only counts when it coincides with the final bin
                w_peak_accept = peak_valid &&
                                ((r_state_q == c_WAIT_PEAK) || w_last_bin);
                if ((r_state_q == c_RUN) && bin_valid) begin
                    w_bin_cnt_d = r_bin_cnt_q + 1'b1;
                    if (w_last_bin) w_state_d = c_WAIT_PEAK;
                end
                if (w_peak_accept) begin
                    if (peak_mag >= threshold) begin
                        w_pitch_data_d = peak_k;
                        w_last_pitch_d = peak_k;
                        w_silent_cnt_d = '0;
                    end else if (r_silent_cnt_q < c_SIL_W'(HOLD_FRAMES)) begin
                        w_pitch_data_d = r_last_pitch_q;
                        w_silent_cnt_d = r_silent_cnt_q + 1'b1;
                    end else begin
                        w_pitch_data_d = '0;
                    end
                    w_pitch_valid_d = 1'b1;
                    w_state_d       = c_PUBLISH;
                end else if (r_watchdog_q <= c_WD_W'(1)) begin
                    if (r_timeout_count_q != 8'hFF)
                        w_timeout_count_d = r_timeout_count_q + 8'd1;
                    w_state_d = enable ? c_WAIT_FRAME : c_IDLE;
                end
            end
            c_PUBLISH: begin
                if (pitch_ready) begin
                    w_pitch_valid_d = 1'b0;
                    w_frame_count_d = r_frame_count_q + 16'd1;
                    w_state_d       = enable ? c_WAIT_FRAME : c_IDLE;
                end
            end
            default: w_state_d = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q         <= c_IDLE;
            r_frame_start_q   <= 1'b0;
            r_pitch_valid_q   <= 1'b0;
            r_pitch_data_q    <= '0;
            r_frame_count_q   <= '0;
            r_timeout_count_q <= '0;
            r_last_pitch_q    <= '0;
            r_silent_cnt_q    <= c_SIL_W'(HOLD_FRAMES);
            r_bin_cnt_q       <= '0;
            r_watchdog_q      <= '0;
        end else begin
            r_state_q         <= w_state_d;
            r_frame_start_q   <= w_frame_start_d;
            r_pitch_valid_q   <= w_pitch_valid_d;
            r_pitch_data_q    <= w_pitch_data_d;
            r_frame_count_q   <= w_frame_count_d;
            r_timeout_count_q <= w_timeout_count_d;
            r_last_pitch_q    <= w_last_pitch_d;
            r_silent_cnt_q    <= w_silent_cnt_d;
            r_bin_cnt_q       <= w_bin_cnt_d;
            r_watchdog_q      <= w_watchdog_d;
        end
    end

    assign frame_start   = r_frame_start_q;
    assign pitch_valid   = r_pitch_valid_q;
    assign pitch_data    = r_pitch_data_q;
    assign frame_count   = r_frame_count_q;
    assign timeout_count = r_timeout_count_q;
    assign state         = r_state_q;

endmodule

`default_nettype wire

// File: tb/tb_fft_frame_scheduler.sv
// ============================================================================
//  Module   : tb_fft_frame_scheduler
//  Purpose  : Directed plus randomized frames against a frame-level model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_fft_frame_scheduler;

    localparam int c_NS   = 16;
    localparam int c_WK   = 16;
    localparam int c_WM   = 33;
    localparam int c_TO   = 64;
    localparam int c_HOLD = 2;

    logic            clk = 1'b0;
    logic            reset, enable, frame_ready, bin_valid, peak_valid, pitch_ready;
    logic [c_WK-1:0] peak_k;
    logic [c_WM-1:0] peak_mag, threshold;
    logic            frame_start, pitch_valid;
    logic [c_WK-1:0] pitch_data;
    logic [15:0]     frame_count;
    logic [7:0]      timeout_count;
    logic [2:0]      state;

    int n_checks = 0;
    int n_err    = 0;
    int fs_cnt   = 0;

    // Frame-level reference: last good pitch, silent-frame run, counters
    int m_last   = 0;
    int m_silent = c_HOLD;
    int m_fc     = 0;
    int m_tc     = 0;

    fft_frame_scheduler #(
        .NSamples      (c_NS),
        .W_K           (c_WK),
        .W_MAG         (c_WM),
        .TIMEOUT_CYCLES(c_TO),
        .HOLD_FRAMES   (c_HOLD)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .frame_ready  (frame_ready),
        .frame_start  (frame_start),
        .bin_valid    (bin_valid),
        .peak_valid   (peak_valid),
        .peak_k       (peak_k),
        .peak_mag     (peak_mag),
        .threshold    (threshold),
        .pitch_valid  (pitch_valid),
        .pitch_ready  (pitch_ready),
        .pitch_data   (pitch_data),
        .frame_count  (frame_count),
        .timeout_count(timeout_count),
        .state        (state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (frame_start === 1'b1) fs_cnt++;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int model_decide(input logic [c_WM-1:0] mag,
                                        input logic [c_WM-1:0] thr, input int k);
        if (mag >= thr) begin
            m_last   = k;
            m_silent = 0;
            return k;
        end
        if (m_silent < c_HOLD) begin
            m_silent++;
            return m_last;
        end
        return 0;
    endfunction

    task automatic wait_state(input logic [2:0] s, input int lim);
        int n = 0;
        while (state !== s && n < lim) begin
            tick;
            n++;
        end
        chk("wait_state", {29'd0, state}, {29'd0, s});
    endtask

    task automatic start_and_bins(input int nbins);
        frame_ready = 1'b1;
        tick;
        frame_ready = 1'b0;
        chk("frame_start", {31'd0, frame_start}, 1);
        chk("state_run", {29'd0, state}, 2);
        for (int i = 0; i < nbins; i++) begin
            bin_valid = 1'b1;
            tick;
        end
        bin_valid = 1'b0;
    endtask

    task automatic run_frame(input logic [c_WK-1:0] k, input logic [c_WM-1:0] mag,
                             input bit early, input bit same, input bit drop_en,
                             input int rdly);
        int fs0;
        int exp_p;
        int gap;
        fs0 = fs_cnt;
        frame_ready = 1'b1;
        tick;
        frame_ready = 1'b0;
        chk("frame_start", {31'd0, frame_start}, 1);
        chk("state_run", {29'd0, state}, 2);
        for (int i = 0; i < c_NS; i++) begin
            gap = $urandom_range(0, 1);
            repeat (gap) begin
                bin_valid  = 1'b0;
                peak_valid = 1'b0;
                tick;
            end
            bin_valid  = 1'b1;
            peak_valid = 1'b0;
            if (early && i == 7) begin
                peak_valid = 1'b1;
                peak_k     = 16'd999;
                peak_mag   = '1;
            end
            if (drop_en && i == 5) enable = 1'b0;
            if (same && i == c_NS - 1) begin
                peak_valid = 1'b1;
                peak_k     = k;
                peak_mag   = mag;
            end
            tick;
        end
        bin_valid  = 1'b0;
        peak_valid = 1'b0;
        if (!same) begin
            gap = $urandom_range(0, 3);
            repeat (gap) begin
                bin_valid = 1'($urandom_range(0, 1));
                tick;
            end
            chk("state_wait_peak", {29'd0, state}, 3);
            bin_valid  = 1'b0;
            peak_valid = 1'b1;
            peak_k     = k;
            peak_mag   = mag;
            tick;
            peak_valid = 1'b0;
        end
        exp_p = model_decide(mag, threshold, int'(k));
        chk("pitch_valid_rise", {31'd0, pitch_valid}, 1);
        chk("pitch_data", {16'd0, pitch_data}, exp_p);
        chk("state_publish", {29'd0, state}, 4);
        peak_k      = 16'($urandom);
        peak_mag    = 33'($urandom);
        frame_ready = 1'b1;
        pitch_ready = 1'b0;
        for (int i = 0; i < rdly; i++) begin
            bin_valid  = 1'($urandom_range(0, 1));
            peak_valid = 1'($urandom_range(0, 1));
            tick;
            chk("hold_valid", {31'd0, pitch_valid}, 1);
            chk("hold_data", {16'd0, pitch_data}, exp_p);
            chk("hold_no_start", {31'd0, frame_start}, 0);
        end
        bin_valid   = 1'b0;
        peak_valid  = 1'b0;
        pitch_ready = 1'b1;
        tick;
        pitch_ready = 1'b0;
        frame_ready = 1'b0;
        m_fc++;
        chk("pitch_valid_fall", {31'd0, pitch_valid}, 0);
        chk("frame_count", {16'd0, frame_count}, m_fc & 32'hFFFF);
        chk("fs_pulses", fs_cnt - fs0, 1);
        chk("state_after", {29'd0, state}, enable ? 1 : 0);
    endtask

    task automatic check_reset_outputs;
        chk("rst_state", {29'd0, state}, 0);
        chk("rst_frame_start", {31'd0, frame_start}, 0);
        chk("rst_pitch_valid", {31'd0, pitch_valid}, 0);
        chk("rst_pitch_data", {16'd0, pitch_data}, 0);
        chk("rst_frame_count", {16'd0, frame_count}, 0);
        chk("rst_timeout_count", {24'd0, timeout_count}, 0);
    endtask

    task automatic apply_reset;
        reset = 1'b1;
        tick;
        check_reset_outputs();
        reset    = 1'b0;
        m_last   = 0;
        m_silent = c_HOLD;
        m_fc     = 0;
        m_tc     = 0;
    endtask

    initial begin
        reset       = 1'b1;
        enable      = 1'b0;
        frame_ready = 1'b0;
        bin_valid   = 1'b0;
        peak_valid  = 1'b0;
        pitch_ready = 1'b0;
        peak_k      = '0;
        peak_mag    = '0;
        threshold   = 33'd500;
        repeat (3) tick;
        check_reset_outputs();
        reset  = 1'b0;
        enable = 1'b1;
        wait_state(3'd1, 4);

        // Basic frame, then hold-over through silence and recovery
        run_frame(16'd37, 33'd1000, 0, 0, 0, 0);
        chk("first_pitch", {16'd0, pitch_data}, 37);
        run_frame(16'd5, 33'd100, 0, 0, 0, 0);
        run_frame(16'd5, 33'd100, 0, 0, 0, 0);
        run_frame(16'd5, 33'd100, 0, 0, 0, 0);
        chk("silence_pitch", {16'd0, pitch_data}, 0);
        run_frame(16'd12, 33'd900, 0, 0, 0, 0);

        // Stalled FFT: watchdog expiry lands exactly TIMEOUT cycles after the start edge
        start_and_bins(10);
        repeat (c_TO - 1 - 10) tick;
        chk("wd_not_yet", {29'd0, state}, 2);
        tick;
        m_tc++;
        chk("wd_state", {29'd0, state}, 1);
        chk("wd_count", {24'd0, timeout_count}, m_tc);
        chk("wd_no_publish", {31'd0, pitch_valid}, 0);
        chk("wd_frame_count", {16'd0, frame_count}, m_fc);
        run_frame(16'd44, 33'd700, 0, 0, 0, 1);

        frame_ready = 1'b1;
        repeat (300 * (c_TO + 1)) tick;
        frame_ready = 1'b0;
        wait_state(3'd1, c_TO + 8);
        m_tc = (m_tc + 300 > 255) ? 255 : m_tc + 300;
        chk("wd_saturate", {24'd0, timeout_count}, m_tc);

        // Back-pressure on the pitch output
        run_frame(16'd77, 33'd2000, 0, 0, 0, 20);

        // Early peak ignored, coincident peak accepted; enable dropped mid-frame
        run_frame(16'd21, 33'd800, 1, 1, 0, 0);
        chk("coincident_pitch", {16'd0, pitch_data}, 21);
        run_frame(16'd9, 33'd50, 0, 0, 1, 2);
        chk("idle_after_drop", {29'd0, state}, 0);
        enable = 1'b1;
        wait_state(3'd1, 4);

        for (int n = 0; n < 8; n++) begin
            threshold = 33'($urandom_range(0, 2000));
            run_frame(16'($urandom_range(1, 60000)), 33'($urandom_range(0, 2000)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0,
                      $urandom_range(0, 3));
        end
        threshold = 33'd500;

        // Reset in WAIT_PEAK and in PUBLISH aborts the frame
        start_and_bins(c_NS);
        chk("pre_rst_wait_peak", {29'd0, state}, 3);
        apply_reset();
        wait_state(3'd1, 4);
        start_and_bins(c_NS);
        peak_valid = 1'b1;
        peak_k     = 16'd88;
        peak_mag   = 33'd5000;
        tick;
        peak_valid = 1'b0;
        chk("pre_rst_publish", {31'd0, pitch_valid}, 1);
        apply_reset();
        wait_state(3'd1, 4);
        run_frame(16'd33, 33'd10, 0, 0, 0, 0);
        chk("post_rst_silence", {16'd0, pitch_data}, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
